// File: rtl/sipo_frame_ctrl.sv
// Serial-to-parallel framing controller.
// Waits for a start bit, shifts WIDTH data bits LSB-first and checks the stop bit.
// Each good word goes to a one-entry valid/ready output buffer.
// Framing errors are reported as a one-cycle pulse. Words dropped on a full buffer raise a sticky overrun flag.
module sipo_frame_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_en,
    input  logic             s_in,
    output logic [WIDTH-1:0] p_data,
    output logic             p_valid,
    input  logic             p_ready,
    output logic             frame_err,
    output logic             overrun,
    input  logic             clr_err,
    output logic             busy
);

    // Counter value reached while the last data bit is being sampled
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DATA = 2'b01,
        STOP = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_pData;
    logic             r_pValid;
    logic             r_frameErr;
    logic             r_overrun;
    logic             r_busy;

    logic             w_startSeen;
    logic             w_shiftEn;
    logic             w_stopSample;
    logic             w_accept;
    logic             w_bufFree;
    logic             w_load;
    logic             w_drop;
    logic             w_frameErrSet;

    // The consumer takes the held word whenever valid meets ready.
    // The buffer can take a new word if it is empty or is being emptied in this same cycle.
    assign w_accept      = r_pValid && p_ready;
    assign w_bufFree     = !r_pValid || p_ready;
    assign w_load        = w_stopSample && s_in && w_bufFree;
    assign w_drop        = w_stopSample && s_in && !w_bufFree;
    assign w_frameErrSet = w_stopSample && !s_in;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; the FSM only moves on sample strobes
    always_comb begin
        w_nextState  = r_state;
        w_startSeen  = 1'b0;
        w_shiftEn    = 1'b0;
        w_stopSample = 1'b0;
        case (r_state)
            IDLE: begin
                if (bit_en && !s_in) begin
                    w_startSeen = 1'b1;
                    w_nextState = DATA;
                end
            end
            DATA: begin
                if (bit_en) begin
                    w_shiftEn = 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        w_nextState = STOP;
                    end
                end
            end
            STOP: begin
                if (bit_en) begin
                    w_stopSample = 1'b1;
                    w_nextState  = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Data bit counter, restarted by each start bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_startSeen) begin
            r_cnt <= '0;
        end else if (w_shiftEn) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Shift register: new bits enter at the top, so the first bit ends up at bit 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
        end else if (w_shiftEn) begin
            r_shift <= {s_in, r_shift[WIDTH-1:1]};
        end
    end

    // One-entry output buffer; a load wins over an accept in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pData  <= '0;
            r_pValid <= 1'b0;
        end else if (w_load) begin
            r_pData  <= r_shift;
            r_pValid <= 1'b1;
        end else if (w_accept) begin
            r_pValid <= 1'b0;
        end
    end

    // Framing error pulse lasts exactly one cycle after a bad stop sample
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frameErr <= 1'b0;
        end else begin
            r_frameErr <= w_frameErrSet;
        end
    end

    // Sticky overrun; a new drop takes priority over a clear request
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (clr_err) begin
            r_overrun <= 1'b0;
        end
    end

    // Busy is registered alongside the state so it tracks the state exactly
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= (w_nextState != IDLE);
        end
    end

    assign p_data    = r_pData;
    assign p_valid   = r_pValid;
    assign frame_err = r_frameErr;
    assign overrun   = r_overrun;
    assign busy      = r_busy;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Testbench for sipo_frame_ctrl.
// Runs directed frames and then random traffic.
// Every cycle the outputs are compared against a frame-position model of the serial protocol.
module tb_sipo_frame_ctrl;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             bit_en;
    logic             s_in;
    logic [WIDTH-1:0] p_data;
    logic             p_valid;
    logic             p_ready;
    logic             frame_err;
    logic             overrun;
    logic             clr_err;
    logic             busy;

    int checkCount;
    int errorCount;
    int busyCycles;

    // Model: mPhase 0 = idle, 1..WIDTH = waiting for data bit mPhase-1, WIDTH+1 = waiting for stop
    int               mPhase;
    int               mWord;
    logic [WIDTH-1:0] mData;
    logic             mValid;
    logic             mErr;
    logic             mOver;

    sipo_frame_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bit_en    (bit_en),
        .s_in      (s_in),
        .p_data    (p_data),
        .p_valid   (p_valid),
        .p_ready   (p_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .clr_err   (clr_err),
        .busy      (busy)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Advance the reference model by one clock using the inputs currently applied
    task automatic modelStep();
        logic accept;
        logic load;
        logic drop;
        logic errNow;
        accept = mValid && p_ready;
        load   = 1'b0;
        drop   = 1'b0;
        errNow = 1'b0;
        if (rst) begin
            mPhase = 0;
            mWord  = 0;
            mData  = '0;
            mValid = 1'b0;
            mErr   = 1'b0;
            mOver  = 1'b0;
        end else begin
            if (bit_en) begin
                if (mPhase == 0) begin
                    if (!s_in) begin
                        mPhase = 1;
                        mWord  = 0;
                    end
                end else if (mPhase <= WIDTH) begin
                    if (s_in) mWord = mWord + (1 << (mPhase - 1));
                    mPhase = mPhase + 1;
                end else begin
                    mPhase = 0;
                    if (s_in) begin
                        if (!mValid || p_ready) load = 1'b1;
                        else drop = 1'b1;
                    end else begin
                        errNow = 1'b1;
                    end
                end
            end
            mErr = errNow;
            if (load) begin
                mValid = 1'b1;
                mData  = mWord[WIDTH-1:0];
            end else if (accept) begin
                mValid = 1'b0;
            end
            if (drop) mOver = 1'b1;
            else if (clr_err) mOver = 1'b0;
        end
    endtask

    // Apply one cycle of inputs, clock it, then compare every output to the model
    task automatic applyStimulus(input logic en, input logic sIn, input logic rdy, input logic clr, input logic rs);
        bit_en  = en;
        s_in    = sIn;
        p_ready = rdy;
        clr_err = clr;
        rst     = rs;
        @(posedge clk);
        modelStep();
        #1;
        if (busy === 1'b1) busyCycles++;
        checkOutput("p_valid", p_valid, mValid);
        checkOutput("p_data", p_data, mData);
        checkOutput("frame_err", frame_err, mErr);
        checkOutput("overrun", overrun, mOver);
        checkOutput("busy", busy, (mPhase != 0));
    endtask

    // Send start, WIDTH data bits LSB-first and a stop bit.
    // Each strobe is preceded by gap idle cycles that carry random line values.
    task automatic sendFrame(input logic [WIDTH-1:0] word, input logic stopBit, input int gap, input logic rdy);
        logic [WIDTH+1:0] seq;
        seq = {stopBit, word, 1'b0};
        for (int i = 0; i < WIDTH + 2; i++) begin
            for (int g = 0; g < gap; g++) begin
                applyStimulus(1'b0, 1'($urandom_range(0, 1)), rdy, 1'b0, 1'b0);
            end
            applyStimulus(1'b1, seq[i], rdy, 1'b0, 1'b0);
        end
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        busyCycles = 0;
        mPhase = 0;
        mWord  = 0;
        mData  = '0;
        mValid = 1'b0;
        mErr   = 1'b0;
        mOver  = 1'b0;
        bit_en = 1'b0;
        s_in = 1'b1;
        p_ready = 1'b0;
        clr_err = 1'b0;
        rst = 1'b1;

        // T1: reset with random inputs
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        end
        checkOutput("t1_p_valid", p_valid, 0);
        checkOutput("t1_p_data", p_data, 0);
        checkOutput("t1_frame_err", frame_err, 0);
        checkOutput("t1_overrun", overrun, 0);
        checkOutput("t1_busy", busy, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        // T2: back-to-back strobes, frame 0,1,0,1,1,1
        busyCycles = 0;
        sendFrame(4'b1101, 1'b1, 0, 1'b1);
        checkOutput("t2_p_valid", p_valid, 1);
        checkOutput("t2_p_data", p_data, 4'b1101);
        checkOutput("t2_busy_cycles", busyCycles, 5);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("t2_p_valid_drop", p_valid, 0);

        // T3: one strobe in four
        sendFrame(4'b1101, 1'b1, 3, 1'b1);
        checkOutput("t3_p_valid", p_valid, 1);
        checkOutput("t3_p_data", p_data, 4'b1101);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        // T4: bad stop bit, then a good frame
        sendFrame(4'h9, 1'b0, 0, 1'b1);
        checkOutput("t4_frame_err", frame_err, 1);
        checkOutput("t4_p_valid", p_valid, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("t4_frame_err_end", frame_err, 0);
        sendFrame(4'h5, 1'b1, 1, 1'b1);
        checkOutput("t4_good_data", p_data, 4'h5);
        checkOutput("t4_good_valid", p_valid, 1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        // T5: consumer stalled, second word overruns
        sendFrame(4'hA, 1'b1, 0, 1'b0);
        sendFrame(4'h3, 1'b1, 0, 1'b0);
        checkOutput("t5_p_data", p_data, 4'hA);
        checkOutput("t5_p_valid", p_valid, 1);
        checkOutput("t5_overrun", overrun, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("t5_overrun_clr", overrun, 0);
        checkOutput("t5_p_data_held", p_data, 4'hA);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("t5_accepted", p_valid, 0);

        // T6: reset after two data bits, then frame 0x6
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("t6_busy_mid", busy, 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("t6_busy", busy, 0);
        checkOutput("t6_p_valid", p_valid, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("t6_no_valid", p_valid, 0);
        sendFrame(4'h6, 1'b1, 0, 1'b1);
        checkOutput("t6_p_data", p_data, 4'h6);
        checkOutput("t6_p_valid_new", p_valid, 1);

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            applyStimulus(1'($urandom_range(0, 2) != 0),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 15) == 0),
                          1'($urandom_range(0, 299) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
